// File: rtl/reg_bank_read_port.sv
// Register bank with a registered, ack-handshaked read port; 1-cycle read latency, response held until RdAck.
// RdReady is low while a response is outstanding. Define RD_WRITE_BYPASS_EN to forward same-cycle write data to a read.
module reg_bank_read_port #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WAddr,
  input  logic [WIDTH-1:0]  nBitIn,
  input  logic              RdReq,
  input  logic [ADDR_W-1:0] RdAddr,
  output logic              RdReady,
  output logic              RdValid,
  output logic [WIDTH-1:0]  RdData,
  input  logic              RdAck
);

  generate
    if (DEPTH != 2**ADDR_W) begin : g_bad_depth
      $error("reg_bank_read_port: DEPTH must equal 2**ADDR_W");
    end
  endgenerate

  typedef enum logic {IDLE, RESP} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_word;

`ifdef RD_WRITE_BYPASS_EN
  assign rd_word = (WE && (WAddr == RdAddr)) ? nBitIn : mem[RdAddr];
`else
  // Nonblocking write means this sees the pre-write value on a same-address collision.
  assign rd_word = mem[RdAddr];
`endif

  always_ff @(posedge clk) begin
    if (Reset) begin
      mem     <= '{default: '0};
      state   <= IDLE;
      RdReady <= 1'b1;
      RdValid <= 1'b0;
      RdData  <= '0;
    end else begin
      if (WE) begin
        mem[WAddr] <= nBitIn;
      end
      case (state)
        IDLE: begin
          if (RdReq) begin
            RdData  <= rd_word;
            state   <= RESP;
            RdReady <= 1'b0;
            RdValid <= 1'b1;
          end
        end
        RESP: begin
          // RdData is a snapshot: it is never reloaded here, and RdReq is ignored.
          if (RdAck) begin
            state   <= IDLE;
            RdReady <= 1'b1;
            RdValid <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          RdReady <= 1'b1;
          RdValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank_read_port.sv
// Directed bench for reg_bank_read_port; responses are checked by a queue-based monitor.
module tb_reg_bank_read_port;

  logic        clk = 1'b0;
  logic        Reset = 1'b0;
  logic        WE = 1'b0;
  logic [2:0]  WAddr = '0;
  logic [31:0] nBitIn = '0;
  logic        RdReq = 1'b0;
  logic [2:0]  RdAddr = '0;
  logic        RdReady;
  logic        RdValid;
  logic [31:0] RdData;
  logic        RdAck = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] sb[$];
  logic [31:0] cur_exp = '0;
  logic        prev_vld = 1'b0;

  reg_bank_read_port #(.WIDTH(32), .DEPTH(8), .ADDR_W(3)) dut (
    .clk(clk), .Reset(Reset), .WE(WE), .WAddr(WAddr), .nBitIn(nBitIn),
    .RdReq(RdReq), .RdAddr(RdAddr), .RdReady(RdReady), .RdValid(RdValid),
    .RdData(RdData), .RdAck(RdAck)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: a rising RdValid is a new response; while it stays high the data must not move.
  always @(negedge clk) begin
    if (RdValid === 1'b1) begin
      if (prev_vld !== 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_resp: got data 0x%08h, expected no response", RdData);
        end else begin
          cur_exp = sb.pop_front();
          check("resp_data", RdData, cur_exp);
        end
      end else begin
        check("resp_hold", RdData, cur_exp);
      end
    end
    prev_vld = RdValid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("rst_ready", {31'd0, RdReady}, 32'd1);
    check("rst_valid", {31'd0, RdValid}, 32'd0);
    check("rst_data", RdData, 32'd0);
  endtask

  task automatic write(input logic [2:0] a, input logic [31:0] d);
    WE = 1'b1; WAddr = a; nBitIn = d;
    tick();
    WE = 1'b0;
  endtask

  // Issue a read (optionally with a same-cycle write) and push its expected data.
  task automatic issue(input logic [2:0] a, input logic [31:0] exp,
                       input logic we, input logic [2:0] wa, input logic [31:0] wd);
    int waited = 0;
    while (RdReady !== 1'b1 && waited < 10) begin
      tick();
      waited++;
    end
    if (RdReady !== 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL ready_timeout: got RdReady=%b, expected 1", RdReady);
    end
    RdReq = 1'b1; RdAddr = a;
    WE = we; WAddr = wa; nBitIn = wd;
    sb.push_back(exp);
    tick();
    RdReq = 1'b0; WE = 1'b0;
    check("accept_valid", {31'd0, RdValid}, 32'd1);
    check("accept_ready", {31'd0, RdReady}, 32'd0);
  endtask

  task automatic finish_read(input int hold, input logic [31:0] exp);
    for (int i = 0; i < hold; i++) tick();
    RdAck = 1'b1;
    tick();
    RdAck = 1'b0;
    check("ack_valid", {31'd0, RdValid}, 32'd0);
    check("ack_ready", {31'd0, RdReady}, 32'd1);
    check("ack_data_kept", RdData, exp);
  endtask

  task automatic do_read(input logic [2:0] a, input logic [31:0] exp, input int hold);
    issue(a, exp, 1'b0, 3'd0, 32'd0);
    finish_read(hold, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_bypass;
    tick();
    do_reset();
    for (int a = 0; a < 8; a++) do_read(3'(a), 32'h0, 0);

    // Write then read, response held 4 cycles without ack
    write(3'd5, 32'hDEADBEEF);
    do_read(3'd5, 32'hDEADBEEF, 4);

    // Same-cycle write/read collision on one address
    write(3'd2, 32'h11111111);
`ifdef RD_WRITE_BYPASS_EN
    exp_bypass = 32'h22222222;
`else
    exp_bypass = 32'h11111111;
`endif
    issue(3'd2, exp_bypass, 1'b1, 3'd2, 32'h22222222);
    finish_read(1, exp_bypass);
    do_read(3'd2, 32'h22222222, 0);

    // Same-cycle write to a different address
    write(3'd6, 32'h66666666);
    issue(3'd6, 32'h66666666, 1'b1, 3'd7, 32'h77777777);
    finish_read(0, 32'h66666666);
    do_read(3'd7, 32'h77777777, 0);

    // Write and request during RESP must not disturb the snapshot or queue a read
    write(3'd3, 32'hA5A5A5A5);
    issue(3'd3, 32'hA5A5A5A5, 1'b0, 3'd0, 32'd0);
    WE = 1'b1; WAddr = 3'd3; nBitIn = 32'h5A5A5A5A; RdReq = 1'b1; RdAddr = 3'd4;
    tick();
    WE = 1'b0; RdReq = 1'b0;
    check("resp_snapshot", RdData, 32'hA5A5A5A5);
    check("resp_ready_low", {31'd0, RdReady}, 32'd0);
    finish_read(2, 32'hA5A5A5A5);
    tick(); tick(); tick();
    check("no_second_resp", {31'd0, RdValid}, 32'd0);
    do_read(3'd3, 32'h5A5A5A5A, 0);

    // Ack in IDLE is ignored
    RdAck = 1'b1;
    tick();
    RdAck = 1'b0;
    check("idle_ack_ready", {31'd0, RdReady}, 32'd1);
    check("idle_ack_valid", {31'd0, RdValid}, 32'd0);

    // Reset aborts a pending response and wins over a same-cycle write/request
    issue(3'd5, 32'hDEADBEEF, 1'b0, 3'd0, 32'd0);
    tick();
    WE = 1'b1; WAddr = 3'd1; nBitIn = 32'h12345678; RdReq = 1'b1; RdAddr = 3'd5;
    do_reset();
    WE = 1'b0; RdReq = 1'b0;
    tick();
    check("post_rst_idle", {31'd0, RdValid}, 32'd0);
    for (int a = 0; a < 8; a++) do_read(3'(a), 32'h0, 0);

    tick(); tick();
    check("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
